// File: rtl/start_seq.sv
// Start-table sequencer: a list of boot table numbers with restart counting.
// A reset edge counts as a restart; LIMIT unacknowledged restarts advance the list.
module start_seq #(
  parameter int TABLE_W    = 8,
  parameter int DEPTH      = 4,
  parameter int CNT_W      = 4,
  parameter int LIMIT_INIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DEPTH - 1);
  localparam logic [4:0]       DEPTH_W5   = 5'(DEPTH);
  localparam logic [CNT_W-1:0] LIMIT_PWR  = CNT_W'(LIMIT_INIT);

  // Configuration-time values only: rst must never clear these registers.
  logic [TABLE_W-1:0] slot [DEPTH] = '{default: '0};
  logic [IDX_W-1:0]   idx       = '0;
  logic [CNT_W-1:0]   count     = '0;
  logic [CNT_W-1:0]   limit     = LIMIT_PWR;
  logic               armed     = 1'b0;
  logic               exhausted = 1'b0;
  logic               rst_q     = 1'b0;

  logic [IDX_W-1:0] idx_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic [CNT_W-1:0] limit_nxt;
  logic             armed_nxt;
  logic             exhausted_nxt;

  logic [7:0]       ctrl;
  logic [7:0]       value;
  logic [3:0]       sel;
  logic             sel_ok;
  logic             restart;
  logic             wr_en;
  logic [CNT_W:0]   count_inc;
  logic             unused_bits;

  assign ctrl        = data_in[7:0];
  assign value       = data_in[15:8];
  assign sel         = data_in[19:16];
  assign sel_ok      = ({1'b0, sel} < DEPTH_W5);
  assign restart     = rst & ~rst_q;
  assign wr_en       = wr & ~rst;
  assign count_inc   = {1'b0, count} + {{CNT_W{1'b0}}, 1'b1};
  assign unused_bits = ^{data_in[31:20], value, ctrl[7]};

  // Restart and write never coincide because writes are dropped while rst is high.
  always_comb begin
    idx_nxt       = idx;
    count_nxt     = count;
    limit_nxt     = limit;
    armed_nxt     = armed;
    exhausted_nxt = exhausted;

    if (restart && armed && !exhausted) begin
      if (limit == '0) begin
        if (count != '1) count_nxt = count_inc[CNT_W-1:0];
      end else if (count_inc >= {1'b0, limit}) begin
        count_nxt = '0;
        if (idx != LAST_IDX) begin
          idx_nxt = idx + IDX_W'(1);
        end else begin
          armed_nxt     = 1'b0;
          exhausted_nxt = 1'b1;
        end
      end else begin
        count_nxt = count_inc[CNT_W-1:0];
      end
    end

    if (wr_en) begin
      if (ctrl[1]) armed_nxt = 1'b1;
      if (ctrl[2]) armed_nxt = 1'b0;
      if (ctrl[3]) count_nxt = '0;
      if (ctrl[4]) limit_nxt = value[CNT_W-1:0];
      if (ctrl[5]) begin
        idx_nxt       = '0;
        count_nxt     = '0;
        exhausted_nxt = 1'b0;
      end else if (ctrl[6] && sel_ok) begin
        idx_nxt   = sel[IDX_W-1:0];
        count_nxt = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    rst_q     <= rst;
    idx       <= idx_nxt;
    count     <= count_nxt;
    limit     <= limit_nxt;
    armed     <= armed_nxt;
    exhausted <= exhausted_nxt;
    if (wr_en && ctrl[0] && sel_ok) slot[sel[IDX_W-1:0]] <= value[TABLE_W-1:0];
  end

  always_comb begin
    data_out                 = '0;
    data_out[TABLE_W-1:0]    = slot[idx];
    data_out[8 +: IDX_W]     = idx;
    data_out[12 +: CNT_W]    = count;
    data_out[20 +: CNT_W]    = limit;
    data_out[28]             = armed;
    data_out[29]             = exhausted;
  end

endmodule

// File: tb/tb_start_seq.sv
// Self-checking bench for start_seq: directed vector table, multi-cycle
// restart sequences, then random traffic against a behavioural model.
module tb_start_seq;

  localparam int DEPTH   = 4;
  localparam int CNT_MAX = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        r;
    logic        w;
    logic [31:0] d;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model state: plain integers following the written rules.
  int m_slot[DEPTH];
  int m_idx, m_count, m_limit;
  bit m_armed, m_exh, m_rst_prev;

  start_seq dut (
    .clk(clk),
    .rst(rst),
    .wr(wr),
    .data_in(data_in),
    .data_out(data_out)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic r, logic w, logic [31:0] d, logic [31:0] e, string n);
    vec_t v;
    v.r = r; v.w = w; v.d = d; v.exp = e; v.name = n;
    return v;
  endfunction

  function automatic logic [31:0] cmd(int ctrl, int value, int s);
    return 32'((s << 16) | (value << 8) | ctrl);
  endfunction

  function automatic logic [31:0] model_word();
    int w;
    w = (m_slot[m_idx] & 255) | (m_idx << 8) | (m_count << 12) | (m_limit << 20)
        | (int'(m_armed) << 28) | (int'(m_exh) << 29);
    return 32'(w);
  endfunction

  task automatic model_step(input logic r, input logic w, input logic [31:0] d);
    int ctrl, value, s;
    ctrl  = int'(d[7:0]);
    value = int'(d[15:8]);
    s     = int'(d[19:16]);
    if (r && !m_rst_prev && m_armed && !m_exh) begin
      if (m_limit == 0) begin
        m_count = (m_count < CNT_MAX) ? m_count + 1 : CNT_MAX;
      end else if (m_count + 1 >= m_limit) begin
        m_count = 0;
        if (m_idx < DEPTH - 1) m_idx = m_idx + 1;
        else begin
          m_armed = 0;
          m_exh   = 1;
        end
      end else begin
        m_count = m_count + 1;
      end
    end
    if (w && !r) begin
      if (ctrl[0] && s < DEPTH) m_slot[s] = value;
      if (ctrl[1]) m_armed = 1;
      if (ctrl[2]) m_armed = 0;
      if (ctrl[3]) m_count = 0;
      if (ctrl[4]) m_limit = value % (CNT_MAX + 1);
      if (ctrl[5]) begin
        m_idx = 0; m_count = 0; m_exh = 0;
      end else if (ctrl[6] && s < DEPTH) begin
        m_idx = s; m_count = 0;
      end
    end
    m_rst_prev = r;
  endtask

  task automatic applyStimulus(input logic r, input logic w, input logic [31:0] d);
    rst = r;
    wr = w;
    data_in = d;
    model_step(r, w, d);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] exp);
    checks++;
    if (data_out !== exp) begin
      errors++;
      $display("[TB] FAIL %s: data_out=%h expected=%h", name, data_out, exp);
    end
  endtask

  task automatic pulseReset();
    applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_slot[i] = 0;
    m_idx = 0; m_count = 0; m_limit = 3;
    m_armed = 0; m_exh = 0; m_rst_prev = 0;

    #1;
    checkOutput("powerup", 32'h0030_0000);

    vecs.push_back(mk(0, 0, 32'h0, 32'h0030_0000, "idle"));
    vecs.push_back(mk(1, 0, 32'h0, 32'h0030_0000, "disarmed_rst1"));
    vecs.push_back(mk(0, 0, 32'h0, 32'h0030_0000, "disarmed_rel1"));
    vecs.push_back(mk(1, 0, 32'h0, 32'h0030_0000, "disarmed_rst2"));
    vecs.push_back(mk(0, 0, 32'h0, 32'h0030_0000, "disarmed_rel2"));
    vecs.push_back(mk(0, 1, cmd(8'h01, 8'h11, 0), 32'h0030_0011, "slot0"));
    vecs.push_back(mk(0, 1, cmd(8'h01, 8'h22, 1), 32'h0030_0011, "slot1"));
    vecs.push_back(mk(0, 1, cmd(8'h01, 8'h33, 2), 32'h0030_0011, "slot2"));
    vecs.push_back(mk(0, 1, cmd(8'h01, 8'h44, 3), 32'h0030_0011, "slot3"));
    vecs.push_back(mk(0, 1, cmd(8'h02, 0, 0), 32'h1030_0011, "arm"));
    vecs.push_back(mk(1, 0, 32'h0, 32'h1030_1011, "restart_cnt1"));
    vecs.push_back(mk(0, 0, 32'h0, 32'h1030_1011, "release1"));
    vecs.push_back(mk(1, 0, 32'h0, 32'h1030_2011, "restart_cnt2"));
    vecs.push_back(mk(0, 0, 32'h0, 32'h1030_2011, "release2"));
    vecs.push_back(mk(1, 0, 32'h0, 32'h1030_0122, "restart_advance"));
    vecs.push_back(mk(0, 0, 32'h0, 32'h1030_0122, "release3"));
    vecs.push_back(mk(1, 1, cmd(8'h04, 0, 0), 32'h1030_1122, "write_during_rst"));
    vecs.push_back(mk(0, 0, 32'h0, 32'h1030_1122, "release4"));
    vecs.push_back(mk(0, 1, cmd(8'h06, 0, 0), 32'h0030_1122, "arm_and_disarm"));
    vecs.push_back(mk(0, 1, cmd(8'h40, 0, 5), 32'h0030_1122, "select_invalid"));
    vecs.push_back(mk(0, 1, cmd(8'h40, 0, 3), 32'h0030_0344, "select3"));
    vecs.push_back(mk(0, 1, cmd(8'h60, 0, 2), 32'h0030_0011, "rewind_over_select"));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].r, vecs[i].w, vecs[i].d);
      checkOutput(vecs[i].name, vecs[i].exp);
    end

    // Walk the whole list until it disarms itself.
    applyStimulus(1'b0, 1'b1, cmd(8'h02, 0, 0));
    for (int i = 0; i < 12; i++) begin
      pulseReset();
      checkOutput("walk_model", model_word());
    end
    checkOutput("exhausted", 32'h2030_0344);
    for (int i = 0; i < 3; i++) pulseReset();
    checkOutput("exhausted_stable", 32'h2030_0344);
    applyStimulus(1'b0, 1'b1, cmd(8'h20, 0, 0));
    checkOutput("rewind", 32'h0030_0011);

    // Acknowledged restarts never advance the pointer.
    applyStimulus(1'b0, 1'b1, cmd(8'h02, 0, 0));
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("ack_loop_rst", 32'h1030_1011);
      applyStimulus(1'b0, 1'b1, cmd(8'h08, 0, 0));
      checkOutput("ack_loop_ack", 32'h1030_0011);
    end
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("rst_held", 32'h1030_1011);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("rst_released", 32'h1030_1011);

    // Zero limit: counter saturates and the pointer stays put.
    applyStimulus(1'b0, 1'b1, cmd(8'h18, 0, 0));
    checkOutput("limit_zero", 32'h1000_0011);
    for (int i = 0; i < 300; i++) pulseReset();
    checkOutput("count_saturated", 32'h1000_F011);

    applyStimulus(1'b0, 1'b1, cmd(8'h18, 3, 0));
    checkOutput("limit_restore", model_word());

    for (int i = 0; i < 1500; i++) begin
      logic        r, w;
      int          ctrl, value, s;
      r = ($urandom_range(0, 3) == 0);
      w = ($urandom_range(0, 1) == 1);
      ctrl = int'($urandom & $urandom & $urandom & 32'hFF);
      if ($urandom_range(0, 3) == 0) ctrl = ctrl | 2;
      value = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 4)) : int'($urandom_range(0, 255));
      s = int'($urandom_range(0, 5));
      applyStimulus(r, w, cmd(ctrl, value, s));
      checkOutput("random", model_word());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
